// File: rtl/br_pkg.sv
// Shared constants and helpers for the register bank with busy scoreboard.
package br_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int ADDR_W_DEF = 5;
  // Widest flattened port vector the field helper can slice.
  localparam int FLAT_MAX   = 256;

  // A write or busy mark lands unless it targets the hardwired-zero register.
  function automatic logic br_wr_keep(input logic en, input logic at_zero,
                                      input logic zero_reg);
    return en && !(zero_reg && at_zero);
  endfunction

  function automatic logic [FLAT_MAX-1:0] br_field(input logic [FLAT_MAX-1:0] v,
                                                   input int unsigned i,
                                                   input int unsigned w);
    logic [FLAT_MAX-1:0] mask;
    mask = (FLAT_MAX'(1) << w) - FLAT_MAX'(1);
    return (v >> (i * w)) & mask;
  endfunction

endpackage

// File: rtl/banco_reg_sb_score.sv
// Busy scoreboard: one busy bit per register plus a registered population count.
module banco_reg_sb_score
  import br_pkg::*;
#(
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int ZERO_REG = 1,
  localparam int DEPTH   = 2 ** ADDR_W
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic [ADDR_W-1:0] SA,
  input  logic              SE,
  input  logic [ADDR_W-1:0] WA,
  input  logic              WE,
  output logic [DEPTH-1:0]  busy,
  output logic [ADDR_W:0]   nbusy
);

  logic             set_en;
  logic             clr_en;
  logic             inc;
  logic             dec;
  logic [DEPTH-1:0] busy_n;
  logic [ADDR_W:0]  nbusy_n;

  always_comb begin
    set_en  = br_wr_keep(SE, SA == '0, ZERO_REG != 0);
    // A fresh producer on the same register outranks the retiring one.
    clr_en  = br_wr_keep(WE, WA == '0, ZERO_REG != 0) && !(set_en && SA == WA);
    inc     = set_en && !busy[SA];
    dec     = clr_en && busy[WA];
    busy_n  = busy;
    if (clr_en) busy_n[WA] = 1'b0;
    if (set_en) busy_n[SA] = 1'b1;
    nbusy_n = nbusy;
    case ({inc, dec})
      2'b10:   nbusy_n = nbusy + 1'b1;
      2'b01:   nbusy_n = nbusy - 1'b1;
      default: nbusy_n = nbusy;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      busy  <= '0;
      nbusy <= '0;
    end else begin
      busy  <= busy_n;
      nbusy <= nbusy_n;
    end
  end

endmodule

// File: rtl/banco_reg_sb.sv
// Register bank with combinational read ports, same-cycle write bypass and busy scoreboard.
module banco_reg_sb
  import br_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int NRD      = 2,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1,
  localparam int DEPTH   = 2 ** ADDR_W
) (
  input  logic                  CLK,
  input  logic                  RST_N,
  input  logic [NRD*ADDR_W-1:0] RA,
  output logic [NRD*DATA_W-1:0] DR,
  output logic [NRD-1:0]        RBSY,
  input  logic [ADDR_W-1:0]     WA,
  input  logic [DATA_W-1:0]     DW,
  input  logic                  WE,
  input  logic [ADDR_W-1:0]     SA,
  input  logic                  SE,
  output logic [ADDR_W:0]       NBUSY
);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DEPTH-1:0]  busy;
  logic              wr_en;
  logic              fwd_en;
  logic [ADDR_W-1:0] ra_i;

  assign wr_en  = br_wr_keep(WE, WA == '0, ZERO_REG != 0);
  // Forwarding is held off during reset so outputs show only the cleared state.
  assign fwd_en = (BYPASS != 0) && wr_en && RST_N;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      for (int r = 0; r < DEPTH; r++) mem[r] <= '0;
    end else if (wr_en) begin
      mem[WA] <= DW;
    end
  end

  banco_reg_sb_score #(
    .ADDR_W  (ADDR_W),
    .ZERO_REG(ZERO_REG)
  ) u_score (
    .CLK  (CLK),
    .RST_N(RST_N),
    .SA   (SA),
    .SE   (SE),
    .WA   (WA),
    .WE   (WE),
    .busy (busy),
    .nbusy(NBUSY)
  );

  always_comb begin
    DR   = '0;
    RBSY = '0;
    ra_i = '0;
    for (int p = 0; p < NRD; p++) begin
      ra_i = ADDR_W'(br_field(FLAT_MAX'(RA), p, ADDR_W));
      if ((ZERO_REG != 0) && ra_i == '0) begin
        DR[p*DATA_W +: DATA_W] = '0;
        RBSY[p]                = 1'b0;
      end else if (fwd_en && WA == ra_i) begin
        DR[p*DATA_W +: DATA_W] = DW;
        RBSY[p]                = 1'b0;
      end else begin
        DR[p*DATA_W +: DATA_W] = mem[ra_i];
        RBSY[p]                = busy[ra_i];
      end
    end
  end

endmodule
